// File: rtl/tpu_operand_loader.sv
// -----------------------------------------------------------------------------
// tpu_operand_loader
//
// Upstream feeder for the NxN weight-stationary systolic array in tt_um_tpu.
// Collects a byte stream into a weight matrix W and an activation matrix A.
// Both are stored row-major. Once both are complete, the loader pulses w_load
// for one cycle with w_out holding W. It then streams A into the row lanes with
// diagonal skew for 2N-1 cycles, and finally pulses done.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   DATA_W-bit element from the pin interface
//   in_valid  in_data is valid this cycle
//   in_sel    target matrix: 0 = weights, 1 = activations
//   in_ready  loader accepts a byte for the matrix selected by in_sel
//   w_out     weight matrix, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//   w_load    one-cycle strobe: array latches w_out
//   a_row     skewed activation lanes, lane i at [i*DATA_W +: DATA_W]
//   a_valid   per-lane valid for a_row
//   busy      high while loading weights or feeding activations
//   done      one-cycle pulse after the last feed cycle
//
// Build option:
//   LOADER_REUSE_W_EN  keep W (and its full flag) across launches, so each
//                      later launch needs only a fresh activation matrix.
// -----------------------------------------------------------------------------
module tpu_operand_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_sel,
  output logic                     in_ready,
  output logic [N*N*DATA_W-1:0]    w_out,
  output logic                     w_load,
  output logic [N*DATA_W-1:0]      a_row,
  output logic [N-1:0]             a_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int NE = N * N;
  localparam int CW = (NE > 1) ? $clog2(NE) : 1;
  localparam int TW = ((2 * N - 1) > 1) ? $clog2(2 * N - 1) : 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(NE - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(2 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WLOAD = 2'd1,
    S_FEED  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [NE*DATA_W-1:0] w_buf, a_buf;
  logic [NE*DATA_W-1:0] w_buf_nxt, a_buf_nxt;
  logic [CW-1:0]        w_cnt, a_cnt;
  logic                 w_full, a_full;
  logic [TW-1:0]        feed_t;

  logic w_acc, a_acc;
  logic w_last, a_last;
  logic w_set, a_set;

  // Byte acceptance: a byte lands only when the loader is ready for its matrix.
  always_comb begin
    w_acc  = in_valid && in_ready && !in_sel;
    a_acc  = in_valid && in_ready &&  in_sel;
    w_last = w_acc && (w_cnt == LAST_IDX);
    a_last = a_acc && (a_cnt == LAST_IDX);
    // Full flags as they will be after this edge; lets the launch start in
    // the cycle right after the completing byte.
    w_set  = w_full || w_last;
    a_set  = a_full || a_last;
  end

  always_comb begin
    w_buf_nxt = w_buf;
    a_buf_nxt = a_buf;
    if (w_acc) w_buf_nxt[int'(w_cnt)*DATA_W +: DATA_W] = in_data;
    if (a_acc) a_buf_nxt[int'(a_cnt)*DATA_W +: DATA_W] = in_data;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (w_set && a_set) state_nxt = S_WLOAD;
      S_WLOAD: state_nxt = S_FEED;
      S_FEED:  if (feed_t == LAST_T) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffers, counters, flags and the latched weight matrix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_buf  <= '0;
      a_buf  <= '0;
      w_cnt  <= '0;
      a_cnt  <= '0;
      w_full <= 1'b0;
      a_full <= 1'b0;
      w_out  <= '0;
      feed_t <= '0;
    end else begin
      w_buf <= w_buf_nxt;
      a_buf <= a_buf_nxt;

      if (w_acc) w_cnt <= w_last ? '0 : w_cnt + 1'b1;
      if (a_acc) a_cnt <= a_last ? '0 : a_cnt + 1'b1;
      if (w_last) w_full <= 1'b1;
      if (a_last) a_full <= 1'b1;

      // Capture W including a completing byte written on this same edge;
      // w_out then stays put until the next launch.
      if (state == S_IDLE && state_nxt == S_WLOAD) w_out <= w_buf_nxt;

      feed_t <= (state == S_FEED) ? feed_t + 1'b1 : '0;

      // No bytes are accepted in DONE, so these clears never race a write.
      if (state == S_DONE) begin
        a_full <= 1'b0;
        a_cnt  <= '0;
`ifdef LOADER_REUSE_W_EN
        // W stays resident for the next launch.
`else
        w_full <= 1'b0;
        w_cnt  <= '0;
`endif
      end
    end
  end

  // Outputs: decoded from registered state, so reset zeroes them at once
  always_comb begin
    in_ready = 1'b0;
    w_load   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    a_row    = '0;
    a_valid  = '0;
    case (state)
      S_IDLE:  in_ready = !rst && !(in_sel ? a_full : w_full);
      S_WLOAD: begin
        w_load = 1'b1;
        busy   = 1'b1;
      end
      S_FEED: begin
        busy = 1'b1;
        // Lane i carries column i of A, delayed by i cycles: A[r][i] at t=r+i.
        for (int i = 0; i < N; i++) begin
          for (int r = 0; r < N; r++) begin
            if (int'(feed_t) == r + i) begin
              a_valid[i]                  = 1'b1;
              a_row[i*DATA_W +: DATA_W]   = a_buf[(r*N+i)*DATA_W +: DATA_W];
            end
          end
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/tpu_operand_loader.md
Name: tpu_operand_loader

Overview:
- Upstream feeder for the 2x2 weight-stationary systolic array inside tt_um_tpu.
- Deserialises the 8-bit pin-level byte stream into a weight matrix W and an activation matrix A, each NxN.
- Once both matrices are complete, it issues a one-cycle weight-load strobe.
- It then streams A into the array row lanes with diagonal skew and signals completion.

Parameters:
- DATA_W, 8, width of one matrix element in bits.
- N, 2, array dimension; each matrix holds N*N elements.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  byte from the pin interface.
- in_valid  input  1  in_data is valid this cycle.
- in_sel  input  1  target matrix: 0 = weights, 1 = activations.
- in_ready  output  1  loader accepts a byte this cycle.
- w_out  output  N*N*DATA_W  weight matrix; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- w_load  output  1  one-cycle strobe: array latches w_out.
- a_row  output  N*DATA_W  skewed activation lanes; lane i at bits [i*DATA_W +: DATA_W].
- a_valid  output  N  per-lane valid for a_row.
- busy  output  1  high in W_LOAD and FEED.
- done  output  1  one-cycle pulse after the last feed cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is asynchronous and active-high; every register clears immediately on assertion.
- Reset values: w_out=0, a_row=0, a_valid=0, w_load=0, busy=0, done=0, in_ready=0 while rst is high.
  - Buffers, counters and the w_full/a_full flags also clear.
  - State returns to IDLE.
- States and transitions:
  - IDLE → W_LOAD when w_full and a_full are both set.
  - W_LOAD → FEED after exactly 1 cycle.
  - FEED lasts 2N-1 cycles, then → DONE.
  - DONE lasts 1 cycle, then → IDLE.
- in_ready:
  - In IDLE: in_ready = !(in_sel ? a_full : w_full). This is combinational on in_sel.
  - In every other state: in_ready = 0.
- Byte acceptance (accept = in_valid & in_ready):
  - The byte is written to the selected buffer at that buffer's counter, in row-major order.
  - The counter increments; writing element N*N-1 sets the full flag and wraps the counter to 0.
  - The W and A counters are independent. Bytes may interleave between matrices in any order.
- Rejected bytes (in_valid while in_ready is low) are dropped with no side effects.
- Latency: if the byte completing the second matrix is accepted at the edge ending cycle k:
  - w_load=1 and busy=1 in cycle k+1.
  - w_out is stable from cycle k+1 until the next W_LOAD.
  - FEED runs in cycles k+2 .. k+2N.
  - done=1 in cycle k+2N+1.
  - in_ready rises again at k+2N+2 at the earliest.
- Feed skew, with feed cycle index t = 0 .. 2N-2:
  - Lane i presents A[r][i] with a_valid[i]=1 when t = r+i, for 0 ≤ r < N.
  - Otherwise the lane outputs a_row lane = 0 and a_valid[i] = 0.
  - Outside FEED, a_valid = 0 and a_row = 0.
- In DONE: both full flags clear and both counters are 0, unless LOADER_REUSE_W_EN applies (see below).
- Reset mid-operation (any state) aborts immediately; no done pulse is produced.
- Arithmetic: no arithmetic on data; elements pass through bit-exact. Counters are ceil(log2(N*N)) bits wide.

Optional Feature:
- Macro: LOADER_REUSE_W_EN.
- Defined (weight-stationary reuse):
  - DONE clears only a_full; w_full and the W buffer are retained.
  - Subsequent launches need only N*N activation bytes.
  - Every launch still pulses w_load, with unchanged w_out.
  - Weight bytes offered while w_full=1 are refused (in_ready=0 for in_sel=0) until reset.
- Undefined: DONE clears both flags; each launch requires fresh W and A.

Test Plan:
- Reset check: assert rst mid-cycle → all outputs 0 immediately, asynchronously, before the next clk edge. Release → in_ready=1 with in_valid=0.
- Basic load and feed: weights 1,2,3,4 (in_sel=0), then activations 5,6,7,8 (in_sel=1).
  - w_load cycle: w_out=0x04030201.
  - FEED t0: a_row=0x0005, a_valid=01.
  - FEED t1: a_row=0x0607, a_valid=11.
  - FEED t2: a_row=0x0800, a_valid=10.
  - done exactly 1 cycle after t2.
- Interleaved order: bytes sent as A5,W1,A6,W2,W3,A7,A8,W4 → identical w_out and feed sequence to the basic test. w_load occurs in the cycle after W4 is accepted.
- Backpressure:
  - Send a fifth weight byte 9 after W is full → in_ready=0 for in_sel=0, byte dropped, w_out still 0x04030201.
  - Offer bytes during busy → in_ready=0, no buffer change.
- Reset mid-FEED: assert rst at FEED t1 → a_valid=0 at once, no done pulse. A reload of both matrices then produces a normal launch.
- LOADER_REUSE_W_EN defined: after the first launch, send only A = 9,10,11,12 → relaunch with w_out=0x04030201 and FEED lanes 9 / 11,10 / 12. Without the macro, the same stimulus never launches.
